// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle ARM controller: state encoding,
// ALU/cmd/condition codes and small decode helpers.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

  // Decoded data-processing command: ALU op, whether it is supported at all,
  // and whether it is arithmetic (so C and V are meaningful).
  typedef struct packed {
    logic [2:0] alu;
    logic       supported;
    logic       arith;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d = '{alu: ALU_ADD, supported: 1'b0, arith: 1'b0};
    case (cmd)
      CMD_ADD: d = '{alu: ALU_ADD, supported: 1'b1, arith: 1'b1};
      CMD_SUB: d = '{alu: ALU_SUB, supported: 1'b1, arith: 1'b1};
      CMD_AND: d = '{alu: ALU_AND, supported: 1'b1, arith: 1'b0};
      CMD_ORR: d = '{alu: ALU_ORR, supported: 1'b1, arith: 1'b0};
      default: d = '{alu: ALU_ADD, supported: 1'b0, arith: 1'b0};
    endcase
    return d;
  endfunction

  // ARM condition evaluation against a stored {N,Z,C,V}; 1111 never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flag register and combinational condition check.
// FlagWrite[1] loads N,Z; FlagWrite[0] loads C,V.
module multicycle_controller_cond_unit
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagWrite,
  output logic       CondEx
);

  logic [3:0] nzcv;

  // Flag register: cleared by reset, partially loaded from the ALU on request.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nzcv <= 4'b0000;
    end else begin
      if (FlagWrite[1]) nzcv[3:2] <= ALUFlags[3:2];
      if (FlagWrite[0]) nzcv[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondEx = cond_holds(Cond, nzcv);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: state register with next-state logic, plus
// per-state output decode qualified by CondEx and the memory handshake.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         mem_ready,
  output logic         PCWrite,
  output logic         IRWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         AdrSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [2:0]   ALUControl,
  output logic         ByteLoad
);

  state_t     state;
  logic [1:0] op;
  logic       cond_ex;
  logic [1:0] flag_write;
  logic       rd_is_pc;
  cmd_dec_t   cmd;
  logic       unused_instr_bits;

  assign op                = Instr[27:26];
  assign rd_is_pc          = (Instr[15:12] == 4'hF);
  assign cmd               = decode_cmd(Instr[24:21]);
  assign ImmSrc            = op;
  assign RegSrc            = {op == 2'b01, op == 2'b10};
  assign unused_instr_bits = ^Instr[19:16];

  multicycle_controller_cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Instr[31:28]),
    .ALUFlags (ALUFlags),
    .FlagWrite(flag_write),
    .CondEx   (cond_ex)
  );

  // State register and next-state selection; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= Instr[25] ? EXECI : EXECR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= Instr[20] ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (mem_ready || !cond_ex) state <= FETCH;
        EXECR, EXECI: state <= ALUWB;
        ALUWB, BRANCH: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Output decode from the current state; write enables are dropped while reset is low.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    ByteLoad   = 1'b0;
    flag_write = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        ByteLoad  = Instr[22];
        PCWrite   = cond_ex && rd_is_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = cmd.alu;
        if (Instr[20] && cond_ex && cmd.supported) flag_write = {1'b1, cmd.arith};
      end
      ALUWB: begin
        RegWrite = cond_ex && cmd.supported;
        PCWrite  = cond_ex && cmd.supported && rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      flag_write = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model
// expands each instruction into its expected per-cycle control outputs;
// a monitor compares them against the DUT on the falling edge.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic        mem_ready;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ByteLoad;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Instr     (instr[31:12]),
    .ALUFlags  (alu_flags),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .ALUControl(ALUControl),
    .ByteLoad  (ByteLoad)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Expected outputs for one cycle; c_* flags say which field groups are defined.
  typedef struct packed {
    bit       pcw, irw, mw, rw;
    bit       c_adr;
    bit       adr;
    bit       c_src;
    bit       srca;
    bit [1:0] srcb;
    bit       c_res;
    bit [1:0] res;
    bit       c_misc;
    bit [2:0] alu;
    bit       bl;
    bit [1:0] imm, rsrc;
  } exp_t;

  exp_t     scb[$];
  int       n_vec = 0;
  int       n_err = 0;
  bit [3:0] nzcv;   // model flags {N,Z,C,V}

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h (instr %08h)", name, $time, act, exp, instr);
    end
  endtask

  // Monitor: one expected record per clock cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        check("PCWrite", PCWrite, e.pcw);
        check("IRWrite", IRWrite, e.irw);
        check("MemWrite", MemWrite, e.mw);
        check("RegWrite", RegWrite, e.rw);
        if (e.c_adr) check("AdrSrc", AdrSrc, e.adr);
        if (e.c_src) begin
          check("ALUSrcA", ALUSrcA, e.srca);
          check("ALUSrcB", ALUSrcB, e.srcb);
        end
        if (e.c_res) check("ResultSrc", ResultSrc, e.res);
        if (e.c_misc) begin
          check("ALUControl", ALUControl, e.alu);
          check("ByteLoad", ByteLoad, e.bl);
          check("ImmSrc", ImmSrc, e.imm);
          check("RegSrc", RegSrc, e.rsrc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  function automatic exp_t base_exp();
    exp_t e;
    e = '0;
    e.c_misc = 1'b1;
    e.imm    = instr[27:26];
    e.rsrc   = {instr[27:26] == 2'b01, instr[27:26] == 2'b10};
    return e;
  endfunction

  function automatic exp_t fetch_exp();
    exp_t e;
    e = base_exp();
    e.c_adr = 1'b1; e.adr = 1'b0;
    e.c_src = 1'b1; e.srca = 1'b1; e.srcb = 2'b10;
    e.c_res = 1'b1; e.res = 2'b10;
    return e;
  endfunction

  task automatic apply(input bit rst, input bit mr, input bit [3:0] fl, input exp_t e);
    reset     = rst;
    mem_ready = mr;
    alu_flags = fl;
    scb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) apply(1'b0, rbit(), rnd4(), e);
    nzcv = 4'b0000;
  endtask

  // Run one instruction: fs fetch stalls, ms memory stalls, fl = ALU flags in execute.
  // abort_wr pulls reset in the store's final MEMWR cycle instead of completing it.
  task automatic run_instr(input logic [31:0] ins, input int fs, input int ms,
                           input bit [3:0] fl, input bit abort_wr);
    exp_t     e;
    bit       ok, rd15, sup, arith;
    bit [2:0] alu;
    instr = ins;
    ok    = cond_ok(ins[31:28], nzcv);
    rd15  = (ins[15:12] == 4'hF);
    for (int i = 0; i < fs; i++) apply(1'b1, 1'b0, rnd4(), fetch_exp());
    e = fetch_exp(); e.pcw = 1'b1; e.irw = 1'b1;
    apply(1'b1, 1'b1, rnd4(), e);
    e = base_exp();
    e.c_src = 1'b1; e.srca = 1'b1; e.srcb = 2'b10; e.c_res = 1'b1; e.res = 2'b10;
    apply(1'b1, rbit(), rnd4(), e);
    case (ins[27:26])
      2'b10: begin
        e = base_exp();
        e.c_src = 1'b1; e.srca = 1'b0; e.srcb = 2'b01; e.c_res = 1'b1; e.res = 2'b10;
        e.pcw = ok;
        apply(1'b1, rbit(), rnd4(), e);
      end
      2'b01: begin
        e = base_exp();
        e.c_src = 1'b1; e.srca = 1'b0; e.srcb = 2'b01;
        apply(1'b1, rbit(), rnd4(), e);
        if (ins[20]) begin
          e = base_exp(); e.c_adr = 1'b1; e.adr = 1'b1;
          for (int i = 0; i < ms; i++) apply(1'b1, 1'b0, rnd4(), e);
          apply(1'b1, 1'b1, rnd4(), e);
          e = base_exp();
          e.c_res = 1'b1; e.res = 2'b01;
          e.rw = ok; e.pcw = ok && rd15; e.bl = ins[22];
          apply(1'b1, rbit(), rnd4(), e);
        end else if (!ok) begin
          e = base_exp(); e.c_adr = 1'b1; e.adr = 1'b1;
          apply(1'b1, 1'b0, rnd4(), e);
        end else begin
          e = base_exp(); e.c_adr = 1'b1; e.adr = 1'b1; e.mw = 1'b1;
          for (int i = 0; i < ms; i++) apply(1'b1, 1'b0, rnd4(), e);
          if (abort_wr) begin
            e = '0;
            apply(1'b0, 1'b1, rnd4(), e);
            nzcv = 4'b0000;
          end else begin
            apply(1'b1, 1'b1, rnd4(), e);
          end
        end
      end
      2'b00: begin
        case (ins[24:21])
          4'b0100: begin alu = 3'b000; sup = 1; arith = 1; end
          4'b0010: begin alu = 3'b001; sup = 1; arith = 1; end
          4'b0000: begin alu = 3'b010; sup = 1; arith = 0; end
          4'b1100: begin alu = 3'b011; sup = 1; arith = 0; end
          default: begin alu = 3'b000; sup = 0; arith = 0; end
        endcase
        e = base_exp();
        e.c_src = 1'b1; e.srca = 1'b0; e.srcb = ins[25] ? 2'b01 : 2'b00;
        e.alu = alu;
        apply(1'b1, rbit(), fl, e);
        if (ins[20] && ok && sup) begin
          nzcv[3:2] = fl[3:2];
          if (arith) nzcv[1:0] = fl[1:0];
        end
        e = base_exp();
        e.c_res = 1'b1; e.res = 2'b00;
        e.rw = ok && sup; e.pcw = ok && sup && rd15;
        apply(1'b1, rbit(), rnd4(), e);
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [3:0]  cmds [5];
    ins = $urandom;
    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
    if (ins[27:26] == 2'b00) begin
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'($urandom)};
      ins[24:21] = cmds[$urandom_range(0, 4)];
      if (ins[20]) ins[31:28] = 4'hE;
    end
    return ins;
  endfunction

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    alu_flags = 4'b0000;
    instr     = 32'h0;
    nzcv      = 4'b0000;
    do_reset(2);

    run_instr(32'hE0821003, 0, 0, rnd4(), 1'b0);       // ADD R1,R2,R3
    run_instr(32'hE5D10004, 0, 2, rnd4(), 1'b0);       // LDRB, MEMRD held 3 cycles
    run_instr(32'hE2500001, 0, 0, 4'b0100, 1'b0);      // SUBS -> Z=1
    run_instr(32'h0A000002, 0, 0, rnd4(), 1'b0);       // BEQ taken
    run_instr(32'h15811000, 0, 2, rnd4(), 1'b0);       // STRNE with Z=1: skipped
    run_instr(32'hE2500001, 0, 0, 4'b0000, 1'b0);      // SUBS -> Z=0
    run_instr(32'h0A000002, 0, 0, rnd4(), 1'b0);       // BEQ not taken
    run_instr(32'hE08FF003, 1, 0, rnd4(), 1'b0);       // ADD PC,PC,R3
    run_instr(32'hEC000000, 0, 0, rnd4(), 1'b0);       // undefined op
    run_instr(32'hE2500001, 0, 0, 4'b1111, 1'b0);      // SUBS -> NZCV=1111
    run_instr(32'hE5811000, 0, 1, rnd4(), 1'b1);       // STR, reset mid-MEMWR
    run_instr(32'h0A000002, 0, 0, rnd4(), 1'b0);       // BEQ: Z cleared by reset
    run_instr(32'h1A000002, 0, 0, rnd4(), 1'b0);       // BNE: taken
    run_instr(32'h2A000002, 0, 0, rnd4(), 1'b0);       // BCS: C cleared by reset

    for (int k = 0; k < 400; k++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rnd4(), 1'b0);

    check("scoreboard_drained", 4'(scb.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
